// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op codes, fault codes, FSM states and lane width.
package lsu_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [3:0] {
    OpLb  = 4'd0,
    OpLbu = 4'd1,
    OpLh  = 4'd2,
    OpLhu = 4'd3,
    OpLw  = 4'd4,
    OpLwl = 4'd5,
    OpLwr = 4'd6,
    OpSb  = 4'd7,
    OpSh  = 4'd8,
    OpSw  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    FaultNone     = 2'd0,
    FaultMisalign = 2'd1,
    FaultTimeout  = 2'd2
  } fault_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic is_load(input op_e op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLwl, OpLwr};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byteenable/replication and load extract/extend/merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  op_e         i_st_op,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_st_rt_data,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  input  op_e         i_ld_op,
  input  logic [1:0]  i_ld_lane,
  input  logic [31:0] i_ld_readdata,
  input  logic [31:0] i_ld_rt_data,
  output logic [31:0] o_ld_data
);

  logic [LANE_W-1:0] w_byte;
  logic [15:0]       w_half;

  // Halfword and word accesses ignore the low lane bits they cannot use.
  always_comb begin
    o_byteenable = '0;
    o_writedata  = '0;
    unique case (i_st_op)
      OpLb, OpLbu: o_byteenable = 4'b0001 << i_st_lane;
      OpLh, OpLhu: o_byteenable = i_st_lane[1] ? 4'b1100 : 4'b0011;
      OpLw:        o_byteenable = 4'b1111;
      OpLwl:       o_byteenable = 4'b1111 >> (2'd3 - i_st_lane);
      OpLwr:       o_byteenable = 4'b1111 << i_st_lane;
      OpSb: begin
        o_byteenable = 4'b0001 << i_st_lane;
        o_writedata  = {4{i_st_rt_data[7:0]}};
      end
      OpSh: begin
        o_byteenable = i_st_lane[1] ? 4'b1100 : 4'b0011;
        o_writedata  = {2{i_st_rt_data[15:0]}};
      end
      OpSw: begin
        o_byteenable = 4'b1111;
        o_writedata  = i_st_rt_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte    = i_ld_readdata[LANE_W*i_ld_lane +: LANE_W];
    w_half    = i_ld_lane[1] ? i_ld_readdata[31:16] : i_ld_readdata[15:0];
    o_ld_data = '0;
    unique case (i_ld_op)
      OpLb:  o_ld_data = {{(32-LANE_W){w_byte[LANE_W-1]}}, w_byte};
      OpLbu: o_ld_data = {{(32-LANE_W){1'b0}}, w_byte};
      OpLh:  o_ld_data = {{16{w_half[15]}}, w_half};
      OpLhu: o_ld_data = {16'h0000, w_half};
      OpLw:  o_ld_data = i_ld_readdata;
      OpLwl: begin
        unique case (i_ld_lane)
          2'd0: o_ld_data = {i_ld_readdata[7:0], i_ld_rt_data[23:0]};
          2'd1: o_ld_data = {i_ld_readdata[15:0], i_ld_rt_data[15:0]};
          2'd2: o_ld_data = {i_ld_readdata[23:0], i_ld_rt_data[7:0]};
          default: o_ld_data = i_ld_readdata;
        endcase
      end
      OpLwr: begin
        unique case (i_ld_lane)
          2'd0: o_ld_data = i_ld_readdata;
          2'd1: o_ld_data = {i_ld_rt_data[31:24], i_ld_readdata[31:8]};
          2'd2: o_ld_data = {i_ld_rt_data[31:16], i_ld_readdata[31:16]};
          default: o_ld_data = {i_ld_rt_data[31:8], i_ld_readdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit driving an Avalon-MM master with waitrequest timeout.
// Define LSU_ALIGN_TRAP_EN to fault misaligned LH/LHU/SH/LW/SW instead of truncating.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [15:0]       req_offset,
  input  logic [31:0]       req_rt_data,
  input  logic [4:0]        req_rt,
  output logic              rsp_valid,
  output logic              rsp_reg_we,
  output logic [4:0]        rsp_reg_addr,
  output logic [31:0]       rsp_reg_data,
  output logic [1:0]        rsp_fault,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  state_e            r_state, w_state_d;
  op_e               r_op;
  logic [1:0]        r_lane;
  logic [31:0]       r_rt_data;
  logic [4:0]        r_rt;
  logic [15:0]       r_wait_cnt;
  logic              r_avm_read, r_avm_write;
  logic [ADDR_W-1:0] r_avm_addr;
  logic [3:0]        r_avm_be;
  logic [31:0]       r_avm_wdata;
  logic              r_rsp_we;
  logic [31:0]       r_rsp_data;
  logic [1:0]        r_fault;

  op_e               w_op;
  logic [ADDR_W-1:0] w_ea;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ld_data;
  logic [15:0]       w_wait_inc;
  logic              w_accept, w_timeout, w_misalign;

  assign w_op       = op_e'(req_op);
  assign w_ea       = req_base + ADDR_W'(signed'(req_offset));
  assign w_accept   = req_valid && (r_state == StIdle);
  assign w_wait_inc = r_wait_cnt + 16'd1;
  assign w_timeout  = (r_state == StBus) && avm_waitrequest && (w_wait_inc == 16'(TIMEOUT_CYC));

`ifdef LSU_ALIGN_TRAP_EN
  assign w_misalign = ((w_op inside {OpLh, OpLhu, OpSh}) && w_ea[0]) ||
                      ((w_op inside {OpLw, OpSw}) && (w_ea[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .i_st_op      (w_op),
    .i_st_lane    (w_ea[1:0]),
    .i_st_rt_data (req_rt_data),
    .o_byteenable (w_be),
    .o_writedata  (w_wdata),
    .i_ld_op      (r_op),
    .i_ld_lane    (r_lane),
    .i_ld_readdata(avm_readdata),
    .i_ld_rt_data (r_rt_data),
    .o_ld_data    (w_ld_data)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = w_misalign ? StResp : StBus;
      StBus:   if (!avm_waitrequest || w_timeout) w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_op        <= OpLb;
      r_lane      <= '0;
      r_rt_data   <= '0;
      r_rt        <= '0;
      r_wait_cnt  <= '0;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
      r_avm_addr  <= '0;
      r_avm_be    <= '0;
      r_avm_wdata <= '0;
      r_rsp_we    <= 1'b0;
      r_rsp_data  <= '0;
      r_fault     <= FaultNone;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op        <= w_op;
            r_lane      <= w_ea[1:0];
            r_rt_data   <= req_rt_data;
            r_rt        <= req_rt;
            r_wait_cnt  <= '0;
            r_avm_addr  <= {w_ea[ADDR_W-1:2], 2'b00};
            r_avm_be    <= w_be;
            r_avm_wdata <= w_wdata;
            r_rsp_we    <= 1'b0;
            r_rsp_data  <= '0;
            if (w_misalign) begin
              r_fault <= FaultMisalign;
            end else begin
              r_fault     <= FaultNone;
              r_avm_read  <= is_load(w_op);
              r_avm_write <= !is_load(w_op);
            end
          end
        end
        StBus: begin
          if (!avm_waitrequest) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_rsp_we    <= is_load(r_op);
            r_rsp_data  <= w_ld_data;
          end else if (w_timeout) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_fault     <= FaultTimeout;
          end else begin
            r_wait_cnt <= w_wait_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (r_state == StIdle);
  assign rsp_valid      = (r_state == StResp);
  assign rsp_reg_we     = rsp_valid && r_rsp_we;
  assign rsp_reg_addr   = rsp_valid ? r_rt : '0;
  assign rsp_reg_data   = rsp_valid ? r_rsp_data : '0;
  assign rsp_fault      = rsp_valid ? r_fault : '0;
  assign avm_address    = r_avm_addr;
  assign avm_byteenable = r_avm_be;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_avm_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a response scoreboard and a scripted Avalon slave.
module tb_mem_access_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_base;
  logic [15:0] req_offset;
  logic [31:0] req_rt_data;
  logic [4:0]  req_rt;
  logic        rsp_valid;
  logic        rsp_reg_we;
  logic [4:0]  rsp_reg_addr;
  logic [31:0] rsp_reg_data;
  logic [1:0]  rsp_fault;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  typedef struct {
    logic        we;
    logic [4:0]  rt;
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_access_unit #(
    .ADDR_W     (32),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_base       (req_base),
    .req_offset     (req_offset),
    .req_rt_data    (req_rt_data),
    .req_rt         (req_rt),
    .rsp_valid      (rsp_valid),
    .rsp_reg_we     (rsp_reg_we),
    .rsp_reg_addr   (rsp_reg_addr),
    .rsp_reg_data   (rsp_reg_data),
    .rsp_fault      (rsp_fault),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    n_tests++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s:sb_empty: observed unexpected rsp_valid expected none", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, ":we"}, 32'(rsp_reg_we), 32'(e.we));
      chk({tag, ":fault"}, 32'(rsp_fault), 32'(e.fault));
      if (e.we) begin
        chk({tag, ":raddr"}, 32'(rsp_reg_addr), 32'(e.rt));
        chk({tag, ":rdata"}, rsp_reg_data, e.data);
      end
    end
  endtask

  // waits = number of BUS cycles the slave holds waitrequest high; e_cyc = BUS cycles expected.
  task automatic run_op(input string tag, input op_e op, input logic [31:0] base,
                        input logic [15:0] off, input logic [31:0] rt_data, input logic [4:0] rt,
                        input int waits, input logic [31:0] rdata, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wd, input logic e_rd,
                        input logic e_wr, input int e_cyc, input logic e_we,
                        input logic [31:0] e_data, input logic [1:0] e_fault);
    int   c;
    bit   got;
    exp_t e;
    @(negedge clk);
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid       = 1'b1;
    req_op          = op;
    req_base        = base;
    req_offset      = off;
    req_rt_data     = rt_data;
    req_rt          = rt;
    avm_waitrequest = (waits > 0);
    avm_readdata    = rdata;
    e.we = e_we; e.rt = rt; e.data = e_data; e.fault = e_fault;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    c   = 0;
    got = 1'b0;
    for (int g = 0; g < 40 && !got; g++) begin
      if (rsp_valid) begin
        got = 1'b1;
        check_rsp(tag);
      end else begin
        if (avm_read || avm_write) begin
          c++;
          chk({tag, ":addr"}, avm_address, e_addr);
          chk({tag, ":be"}, 32'(avm_byteenable), 32'(e_be));
          chk({tag, ":rd"}, 32'(avm_read), 32'(e_rd));
          chk({tag, ":wr"}, 32'(avm_write), 32'(e_wr));
          if (e_wr) chk({tag, ":wd"}, avm_writedata, e_wd);
          avm_waitrequest = (c <= waits);
        end
        @(negedge clk);
      end
    end
    chk({tag, ":rsp_seen"}, 32'(got), 32'd1);
    chk({tag, ":bus_cycles"}, 32'(c), 32'(e_cyc));
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk({tag, ":pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_op          = 4'd0;
    req_base        = '0;
    req_offset      = '0;
    req_rt_data     = '0;
    req_rt          = '0;
    avm_readdata    = '0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst:ready", 32'(req_ready), 32'd1);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:read", 32'(avm_read), 32'd0);
    chk("rst:write", 32'(avm_write), 32'd0);
    chk("rst:addr", avm_address, 32'd0);
    reset = 1'b0;

    //     tag      op     base          off      rt_data       rt  w   rdata         addr          be       wd            rd wr cyc we data          fault
    run_op("lb",    OpLb,  32'h0000_1000, 16'hFFFF, 32'h0,        5,  0, 32'h8000_0000, 32'h0000_0FFC, 4'b1000, 32'h0,        1, 0, 1, 1, 32'hFFFF_FF80, 2'd0);
    run_op("sh",    OpSh,  32'h0000_2000, 16'h0002, 32'h0000_BEEF, 3,  3, 32'h0,        32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 0, 1, 4, 0, 32'h0,        2'd0);
    run_op("lwl",   OpLwl, 32'h0000_3000, 16'h0001, 32'hAABB_CCDD, 7,  0, 32'h1122_3344, 32'h0000_3000, 4'b0011, 32'h0,        1, 0, 1, 1, 32'h3344_CCDD, 2'd0);
    run_op("lwr",   OpLwr, 32'h0000_3000, 16'h0001, 32'hAABB_CCDD, 8,  1, 32'h1122_3344, 32'h0000_3000, 4'b1110, 32'h0,        1, 0, 2, 1, 32'hAA11_2233, 2'd0);
    run_op("lbu",   OpLbu, 32'h0000_0010, 16'h0002, 32'h0,        9,  0, 32'h12F4_5678, 32'h0000_0010, 4'b0100, 32'h0,        1, 0, 1, 1, 32'h0000_00F4, 2'd0);
    run_op("lh",    OpLh,  32'h0000_0020, 16'h0002, 32'h0,        10, 2, 32'h8001_7FFF, 32'h0000_0020, 4'b1100, 32'h0,        1, 0, 3, 1, 32'hFFFF_8001, 2'd0);
    run_op("lhu",   OpLhu, 32'h0000_0020, 16'h0000, 32'h0,        11, 0, 32'h8001_F00F, 32'h0000_0020, 4'b0011, 32'h0,        1, 0, 1, 1, 32'h0000_F00F, 2'd0);
    run_op("sb",    OpSb,  32'h0000_0040, 16'hFFFD, 32'h1234_56A5, 12, 0, 32'h0,        32'h0000_003C, 4'b0010, 32'hA5A5_A5A5, 0, 1, 1, 0, 32'h0,        2'd0);
    run_op("sw",    OpSw,  32'h0000_0050, 16'h0000, 32'hDEAD_BEEF, 13, 1, 32'h0,        32'h0000_0050, 4'b1111, 32'hDEAD_BEEF, 0, 1, 2, 0, 32'h0,        2'd0);
    run_op("lw_r0", OpLw,  32'h0000_0060, 16'h0000, 32'h0,        0,  0, 32'hCAFE_F00D, 32'h0000_0060, 4'b1111, 32'h0,        1, 0, 1, 1, 32'hCAFE_F00D, 2'd0);
    run_op("wrap",  OpLhu, 32'h0000_0002, 16'hFFFC, 32'h0,        14, 0, 32'hABCD_0000, 32'hFFFF_FFFC, 4'b1100, 32'h0,        1, 0, 1, 1, 32'h0000_ABCD, 2'd0);
    run_op("tmo",   OpLw,  32'h0000_0070, 16'h0000, 32'h0,        15, 99, 32'h0,       32'h0000_0070, 4'b1111, 32'h0,        1, 0, 4, 0, 32'h0,        2'd2);
`ifdef LSU_ALIGN_TRAP_EN
    run_op("mis",   OpLw,  32'h0000_1000, 16'h0001, 32'h0,        16, 0, 32'h5566_7788, 32'h0,        4'b0000, 32'h0,        0, 0, 0, 0, 32'h0,        2'd1);
`else
    run_op("mis",   OpLw,  32'h0000_1000, 16'h0001, 32'h0,        16, 0, 32'h5566_7788, 32'h0000_1000, 4'b1111, 32'h0,        1, 0, 1, 1, 32'h5566_7788, 2'd0);
`endif

    // Reset mid-BUS: outputs drop asynchronously and no response follows.
    @(negedge clk);
    req_valid       = 1'b1;
    req_op          = OpLw;
    req_base        = 32'h0000_0080;
    req_offset      = 16'h0000;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstbus:read_before", 32'(avm_read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstbus:read", 32'(avm_read), 32'd0);
    chk("rstbus:ready", 32'(req_ready), 32'd1);
    chk("rstbus:rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset           = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstbus:no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("sb:drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
